// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N valid/ready stream demultiplexer.
// A single-entry output buffer holds the current beat. It reloads on the
// same edge it drains, so back-to-back beats flow at one beat per cycle
// even when consecutive beats go to different sinks. Each sink has its
// own wrapping counter of delivered beats. A beat whose select is out of
// range is consumed and discarded, and o_err pulses for one cycle.
module demux_stream #(
    parameter int BW_DATA = 8,
    parameter int N_OUT   = 4,
    parameter int BW_SEL  = 2,
    parameter int BW_CNT  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [BW_DATA-1:0]       i_data,
    input  logic [BW_SEL-1:0]        i_sel,
    output logic [N_OUT-1:0]         o_valid,
    input  logic [N_OUT-1:0]         i_ready,
    output logic [BW_DATA-1:0]       o_data,
    output logic [N_OUT*BW_CNT-1:0]  o_cnt,
    output logic                     o_err
);

    logic                 full_q, full_d;
    logic [BW_SEL-1:0]    sel_q, sel_d;
    logic [BW_DATA-1:0]   data_q, data_d;
    logic                 err_q, err_d;
    logic [BW_CNT-1:0]    cnt_q [N_OUT];
    logic [BW_CNT-1:0]    cnt_d [N_OUT];

    logic [N_OUT-1:0]     buf_oh;
    logic                 sel_ready;
    logic                 in_range;
    logic                 accept;
    logic                 drain;

    // Decode the buffered destination and resolve both handshakes.
    always_comb begin
        buf_oh = '0;
        for (int k = 0; k < N_OUT; k++) begin
            buf_oh[k] = (sel_q == BW_SEL'(k));
        end
        // Only the ready of the sink that owns the buffered beat matters.
        sel_ready = |(buf_oh & i_ready);
        in_range  = (32'(i_sel) < 32'(N_OUT));
        drain     = full_q && sel_ready;
        // Readiness never looks at i_valid, so no comb loop through a source.
        o_ready   = !full_q || sel_ready;
        accept    = i_valid && o_ready;
    end

    // Next buffer state: drain empties, an in-range accept (re)loads.
    always_comb begin
        full_d = full_q;
        sel_d  = sel_q;
        data_d = data_q;
        err_d  = 1'b0;
        if (drain) begin
            full_d = 1'b0;
        end
        if (accept) begin
            if (in_range) begin
                full_d = 1'b1;
                sel_d  = i_sel;
                data_d = i_data;
            end else begin
                // Consumed but not stored; an existing beat may still drain.
                err_d = 1'b1;
            end
        end
    end

    // Next per-sink counters: bump the one sink that drains, wrapping.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (drain && buf_oh[k]) begin
                cnt_d[k] = cnt_q[k] + BW_CNT'(1);
            end
        end
    end

    // State registers; a beat held at reset is discarded.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            full_q <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            full_q <= full_d;
            sel_q  <= sel_d;
            data_q <= data_d;
            err_q  <= err_d;
            for (int k = 0; k < N_OUT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Drive outputs straight from registered state.
    always_comb begin
        o_valid = full_q ? buf_oh : '0;
        o_data  = data_q;
        o_err   = err_q;
        o_cnt   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            o_cnt[k*BW_CNT +: BW_CNT] = cnt_q[k];
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed scenarios on a 4-sink instance, the
// out-of-range drop on a 3-sink instance, and randomized traffic checked
// against a queue-based reference of beats owed to the sinks.
module tb_demux_stream;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;

    // 4-sink instance
    logic        v4 = 1'b0;
    logic [7:0]  d4 = '0;
    logic [1:0]  s4 = '0;
    logic [3:0]  r4 = '0;
    logic        rdy4;
    logic [3:0]  ov4;
    logic [7:0]  od4;
    logic [31:0] oc4;
    logic        oe4;

    // 3-sink instance (select code 3 is out of range)
    logic        v3 = 1'b0;
    logic [7:0]  d3 = '0;
    logic [1:0]  s3 = '0;
    logic [2:0]  r3 = '0;
    logic        rdy3;
    logic [2:0]  ov3;
    logic [7:0]  od3;
    logic [23:0] oc3;
    logic        oe3;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } beat_t;

    demux_stream #(.BW_DATA(8), .N_OUT(4), .BW_SEL(2), .BW_CNT(8)) dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(v4), .o_ready(rdy4),
        .i_data(d4), .i_sel(s4), .o_valid(ov4), .i_ready(r4),
        .o_data(od4), .o_cnt(oc4), .o_err(oe4)
    );

    demux_stream #(.BW_DATA(8), .N_OUT(3), .BW_SEL(2), .BW_CNT(8)) dut3 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(v3), .o_ready(rdy3),
        .i_data(d3), .i_sel(s3), .o_valid(ov3), .i_ready(r3),
        .o_data(od3), .o_cnt(oc3), .o_err(oe3)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v4 = 1'b0; v3 = 1'b0; r4 = '0; r3 = '0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        v4 = 1'b0; v3 = 1'b0; r4 = '0; r3 = '0;
        rstn = 1'b0;
        tick();
        n_vec++; if (ov4 !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b want 0000", ov4); end
        n_vec++; if (od4 !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", od4); end
        n_vec++; if (oc4 !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 00000000", oc4); end
        n_vec++; if (oe4 !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", oe4); end
        n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", rdy4); end
        n_vec++; if (ov3 !== 3'b000) begin n_err++; $display("FAIL reset_valid3: got %b want 000", ov3); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ev;
        r4 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; s4 = 2'(i); d4 = 8'hA0 + 8'(i);
            #1;
            n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, rdy4); end
            tick();
            ev = 4'b0001 << i;
            n_vec++; if (ov4 !== ev) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, ov4, ev); end
            n_vec++; if (od4 !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, od4, 8'hA0 + 8'(i)); end
        end
        v4 = 1'b0;
        tick();
        n_vec++; if (ov4 !== 4'b0000) begin n_err++; $display("FAIL b2b_idle: got %b want 0000", ov4); end
        n_vec++; if (oc4 !== 32'h01010101) begin n_err++; $display("FAIL b2b_cnt: got %h want 01010101", oc4); end
    endtask

    task automatic test_stall();
        r4 = 4'b1011;
        v4 = 1'b1; s4 = 2'd2; d4 = 8'h5C;
        tick();
        s4 = 2'd1; d4 = 8'h3D;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (ov4 !== 4'b0100) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 0100", c, ov4); end
            n_vec++; if (od4 !== 8'h5C) begin n_err++; $display("FAIL stall_data[%0d]: got %h want 5c", c, od4); end
            n_vec++; if (rdy4 !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", c, rdy4); end
            tick();
        end
        r4 = 4'b1111;
        #1;
        n_vec++; if (rdy4 !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", rdy4); end
        tick();
        v4 = 1'b0;
        n_vec++; if (ov4 !== 4'b0010) begin n_err++; $display("FAIL stall_next_valid: got %b want 0010", ov4); end
        n_vec++; if (od4 !== 8'h3D) begin n_err++; $display("FAIL stall_next_data: got %h want 3d", od4); end
        tick();
        n_vec++; if (ov4 !== 4'b0000) begin n_err++; $display("FAIL stall_idle: got %b want 0000", ov4); end
        n_vec++; if (oc4 !== 32'h01020201) begin n_err++; $display("FAIL stall_cnt: got %h want 01020201", oc4); end
    endtask

    task automatic test_err();
        // Lone out-of-range beat on an empty buffer
        r3 = 3'b111;
        v3 = 1'b1; s3 = 2'd3; d3 = 8'hFF;
        #1;
        n_vec++; if (rdy3 !== 1'b1) begin n_err++; $display("FAIL err_ready: got %b want 1", rdy3); end
        tick();
        v3 = 1'b0;
        n_vec++; if (ov3 !== 3'b000) begin n_err++; $display("FAIL err_valid: got %b want 000", ov3); end
        n_vec++; if (oe3 !== 1'b1) begin n_err++; $display("FAIL err_pulse: got %b want 1", oe3); end
        n_vec++; if (oc3 !== 24'h0) begin n_err++; $display("FAIL err_cnt: got %h want 000000", oc3); end
        tick();
        n_vec++; if (oe3 !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", oe3); end
        // Out-of-range beat accepted while the buffered beat drains
        r3 = 3'b000;
        v3 = 1'b1; s3 = 2'd1; d3 = 8'h11;
        tick();
        s3 = 2'd3; d3 = 8'hFF; r3 = 3'b010;
        #1;
        n_vec++; if (rdy3 !== 1'b1) begin n_err++; $display("FAIL err_drain_ready: got %b want 1", rdy3); end
        tick();
        v3 = 1'b0;
        n_vec++; if (ov3 !== 3'b000) begin n_err++; $display("FAIL err_drain_valid: got %b want 000", ov3); end
        n_vec++; if (oe3 !== 1'b1) begin n_err++; $display("FAIL err_drain_pulse: got %b want 1", oe3); end
        n_vec++; if (oc3 !== 24'h000100) begin n_err++; $display("FAIL err_drain_cnt: got %h want 000100", oc3); end
        n_vec++; if (oe4 !== 1'b0) begin n_err++; $display("FAIL err_other_inst: got %b want 0", oe4); end
    endtask

    task automatic test_wrap();
        do_reset();
        r4 = 4'b1111;
        for (int i = 0; i < 257; i++) begin
            v4 = 1'b1; s4 = 2'd0; d4 = 8'(i);
            tick();
            if (i == 255) begin
                n_vec++; if (oc4[7:0] !== 8'hFF) begin n_err++; $display("FAIL wrap_255: got %h want ff", oc4[7:0]); end
            end
        end
        v4 = 1'b0;
        tick();
        n_vec++; if (oc4 !== 32'h00000001) begin n_err++; $display("FAIL wrap_cnt: got %h want 00000001", oc4); end
    endtask

    task automatic test_async_reset();
        r4 = 4'b0000;
        v4 = 1'b1; s4 = 2'd1; d4 = 8'h77;
        tick();
        v4 = 1'b0;
        n_vec++; if (ov4 !== 4'b0010) begin n_err++; $display("FAIL async_pre_valid: got %b want 0010", ov4); end
        #2;
        rstn = 1'b0;
        #1;
        n_vec++; if (ov4 !== 4'b0000) begin n_err++; $display("FAIL async_valid: got %b want 0000", ov4); end
        n_vec++; if (oc4 !== 32'h0) begin n_err++; $display("FAIL async_cnt: got %h want 00000000", oc4); end
        n_vec++; if (od4 !== 8'h00) begin n_err++; $display("FAIL async_data: got %h want 00", od4); end
        r4 = 4'b1111;
        #2;
        rstn = 1'b1;
        tick();
        n_vec++; if (ov4 !== 4'b0000) begin n_err++; $display("FAIL async_post_valid: got %b want 0000", ov4); end
        tick();
        n_vec++; if (oc4 !== 32'h0) begin n_err++; $display("FAIL async_post_cnt: got %h want 00000000", oc4); end
    endtask

    task automatic test_random();
        beat_t      q[$];
        beat_t      b;
        logic [7:0] mcnt [4];
        logic [31:0] ecnt;
        logic [3:0] ev;
        logic       eready;
        logic       drn;
        logic       acc;
        int         bad_valid;
        int         bad_data;
        int         bad_ready;
        int         bad_cnt;
        int         bad_oh;

        do_reset();
        for (int k = 0; k < 4; k++) mcnt[k] = '0;
        bad_valid = 0; bad_data = 0; bad_ready = 0; bad_cnt = 0; bad_oh = 0;
        for (int c = 0; c < 1000; c++) begin
            v4 = ($urandom_range(0, 3) != 0);
            s4 = 2'($urandom);
            d4 = 8'($urandom);
            r4 = 4'($urandom) | 4'($urandom);
            #1;
            // What the sinks should see: the oldest undelivered beat, if any
            ev     = (q.size() > 0) ? (4'b0001 << q[0].sel) : 4'b0000;
            eready = (q.size() == 0) || r4[q[0].sel];
            for (int k = 0; k < 4; k++) ecnt[k*8 +: 8] = mcnt[k];
            n_vec++; if (ov4 !== ev) begin n_err++; if (bad_valid++ < 5) $display("FAIL rand_valid@%0d: got %b want %b", c, ov4, ev); end
            if (q.size() > 0) begin
                n_vec++; if (od4 !== q[0].data) begin n_err++; if (bad_data++ < 5) $display("FAIL rand_data@%0d: got %h want %h", c, od4, q[0].data); end
            end
            n_vec++; if (rdy4 !== eready) begin n_err++; if (bad_ready++ < 5) $display("FAIL rand_ready@%0d: got %b want %b", c, rdy4, eready); end
            n_vec++; if (oc4 !== ecnt) begin n_err++; if (bad_cnt++ < 5) $display("FAIL rand_cnt@%0d: got %h want %h", c, oc4, ecnt); end
            n_vec++; if ($countones(ov4) > 1 || oe4 !== 1'b0) begin n_err++; if (bad_oh++ < 5) $display("FAIL rand_onehot@%0d: got valid=%b err=%b want <=1 bit, err=0", c, ov4, oe4); end
            // Advance the reference by this cycle's handshakes
            drn = (q.size() > 0) && r4[q[0].sel];
            acc = v4 && eready;
            if (drn) begin
                b = q.pop_front();
                mcnt[b.sel] = mcnt[b.sel] + 8'd1;
            end
            if (acc) begin
                b.sel = s4; b.data = d4;
                q.push_back(b);
            end
            tick();
        end
        v4 = 1'b0; r4 = 4'b1111;
        #1;
        if (q.size() > 0) begin
            b = q.pop_front();
            mcnt[b.sel] = mcnt[b.sel] + 8'd1;
        end
        tick();
        for (int k = 0; k < 4; k++) ecnt[k*8 +: 8] = mcnt[k];
        n_vec++; if (ov4 !== 4'b0000) begin n_err++; $display("FAIL rand_final_valid: got %b want 0000", ov4); end
        n_vec++; if (oc4 !== ecnt) begin n_err++; $display("FAIL rand_final_cnt: got %h want %h", oc4, ecnt); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_err();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-N stream demultiplexer; the routing counterpart of the 2:1 mux, splitting one valid/ready source stream into N_OUT sink streams.
- Each accepted beat is steered to one sink by its i_sel tag.
- A single-entry output buffer with bypass-on-drain gives 1-cycle latency and full throughput.
- Per-sink beat counters and a drop flag provide status for integration benches.

Parameters:
- BW_DATA, 8, data width in bits.
- N_OUT, 4, number of sink ports (2..16).
- BW_SEL, 2, select width; must satisfy 2**BW_SEL >= N_OUT.
- BW_CNT, 8, width of each per-sink beat counter.

Ports:
- i_clk  input  1  clock; rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  source beat valid.
- o_ready  output  1  block can accept a source beat this cycle.
- i_data  input  BW_DATA  source beat data.
- i_sel  input  BW_SEL  destination sink index for the beat.
- o_valid  output  N_OUT  per-sink valid; at most one bit set (one-hot or zero).
- i_ready  input  N_OUT  per-sink ready.
- o_data  output  BW_DATA  buffered beat data, shared by all sinks, qualified by o_valid.
- o_cnt  output  N_OUT*BW_CNT  per-sink count of delivered beats; sink k occupies bits [k*BW_CNT +: BW_CNT].
- o_err  output  1  one-cycle pulse when a beat with i_sel >= N_OUT is dropped.

Behaviour:
- Reset (i_rstn=0, asynchronous): buffer empty, o_valid=0, o_data=0, all o_cnt=0, o_err=0.
  - Deassertion is sampled on i_clk.
  - A beat buffered at reset is lost, not delivered.
- Internal state: full flag, buf_sel, buf_data.
- o_ready = !full || i_ready[buf_sel]. This is combinational from registered state and i_ready; it never depends on i_valid.
- Accept: i_valid && o_ready at a rising edge.
- Drain: full && i_ready[buf_sel] at a rising edge. i_ready bits of non-selected sinks are ignored.
- o_valid[k] = full && (buf_sel == k). o_data = buf_data.
- Latency: a beat accepted at edge n appears on o_valid/o_data after edge n and stays until the edge where it drains.
- Stalled sink: o_valid, o_data and buf_sel hold stable until drain.
  - No data change while valid and not ready.
  - No valid withdrawal.
- Simultaneous drain and accept in one cycle: buffer reloads with the new beat, full stays 1. This sustains 1 beat/cycle, including back-to-back beats to different sinks.
- Drain without accept: full goes 0 and o_valid goes 0 next cycle.
- Accept while empty: full goes 1.
- Out-of-range select (i_sel >= N_OUT, possible only when N_OUT < 2**BW_SEL):
  - The beat is accepted under the normal o_ready rule.
  - It is not stored; full and buffer contents are unaffected, and an existing buffered beat may still drain in the same cycle.
  - o_err = 1 for exactly the following cycle.
- o_cnt[k] increments by 1 on each drain to sink k and wraps from 2**BW_CNT-1 to 0 with no saturation. Dropped beats do not count.
- Head-of-line blocking is by design: a stalled sink blocks the whole stream.
- o_valid never has more than one bit set.

Test Plan:
- Reset, then set i_ready=4'b1111 and send sel=0..3 with data 8'hA0..8'hA3 back-to-back.
  - Required: o_valid = 0001, 0010, 0100, 1000 on consecutive cycles with matching data.
  - o_ready stays 1 throughout.
  - o_cnt = {1,1,1,1}.
- Hold i_ready[2]=0 and send sel=2, data 8'h5C, followed by sel=1.
  - Required: o_valid=0100 with data 8'h5C held for 5 cycles; o_ready=0 during the stall.
  - Raise i_ready[2] -> 5C drains, sel=1 beat is accepted the same edge, o_valid=0010 the next cycle.
- N_OUT=3, BW_SEL=2: send sel=3 with data 8'hFF.
  - Required: beat accepted, no o_valid bit set, o_err=1 for one cycle, o_cnt unchanged.
- BW_CNT=8: deliver 257 beats to sink 0 -> o_cnt[0]=1 (wrap verified).
- Buffer sel=1 with i_ready=0, then pulse i_rstn low mid-cycle.
  - Required: o_valid=0 and o_cnt=0 immediately (async); no delivery after reset release.
- Random traffic: random i_valid/i_sel/i_ready for 1000 cycles against a scoreboard.
  - Required: every in-range beat delivered once, in order, to the correct sink.
  - o_valid is always one-hot or zero.
